// File: rtl/paper_csc_pkg.sv
// BT.601 limited-range YCbCr->RGB constants and shared types for the paper CSC pipeline.
// Pure declarations: no latency, no backpressure.
package paper_csc_pkg;

  typedef logic signed [19:0] acc_t;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam acc_t K_Y   = 20'sd298;
  localparam acc_t K_RCR = 20'sd409;
  localparam acc_t K_GCB = 20'sd100;
  localparam acc_t K_GCR = 20'sd208;
  localparam acc_t K_BCB = 20'sd516;

  localparam acc_t Y_OFS = 20'sd16;
  localparam acc_t C_OFS = 20'sd128;

  localparam acc_t ROUND = 20'sd128;
  localparam int   SHIFT = 8;

endpackage

// File: rtl/paper_ycbcr422_to_rgb_if.sv
// Pixel-domain video bundle: 4:2:2 input side and RGB output side with syncs.
// Wires only: no latency; the stream has no backpressure.
interface paper_ycbcr422_to_rgb_if;
  logic [15:0] data422_i;
  logic        de_i;
  logic        hsync_i;
  logic        vsync_i;
  logic [23:0] rgb_o;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;

  modport master (
    output data422_i, de_i, hsync_i, vsync_i,
    input  rgb_o, de_o, hsync_o, vsync_o
  );

  modport slave (
    input  data422_i, de_i, hsync_i, vsync_i,
    output rgb_o, de_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/paper_csc_clamp.sv
// Rounds, shifts and clamps one signed accumulator to an 8-bit colour channel.
// Combinational, zero latency; no backpressure.
module paper_csc_clamp
  import paper_csc_pkg::*;
(
  input  acc_t       i_acc,
  output logic [7:0] o_pix
);

  acc_t w_rnd;

  assign w_rnd = (i_acc + ROUND) >>> SHIFT;

  always_comb begin
    o_pix = w_rnd[7:0];
    if (w_rnd < 20'sd0)
      o_pix = 8'h00;
    else if (w_rnd > 20'sd255)
      o_pix = 8'hFF;
  end

endmodule

// File: rtl/paper_ycbcr422_to_rgb.sv
// YCbCr 4:2:2 -> RGB888 (BT.601 limited range) with de/hsync/vsync kept aligned.
// Fixed 3-cycle latency (pair, multiply, sum/clamp); one pixel per cycle, never stalls.
module paper_ycbcr422_to_rgb
  import paper_csc_pkg::*;
(
  input  logic                    px_clk_i,
  input  logic                    rst_ni,
  paper_ycbcr422_to_rgb_if.slave  vid
);

  localparam logic [7:0] C_NEUTRAL = C_OFS[7:0];

  sync_t      w_sync_in;
  logic       w_in_odd;
  logic [7:0] w_cb;
  logic [7:0] w_cr;
  acc_t       w_yd, w_cbd, w_crd;
  acc_t       w_sum_r, w_sum_g, w_sum_b;
  logic [7:0] w_r, w_g, w_b;

  logic       r_phase;
  logic [7:0] r_s1_y;
  logic [7:0] r_s1_c;
  logic       r_s1_odd;
  logic [7:0] r_cb_lat;
  sync_t      r_s1_sync;
  acc_t       r_p_y, r_p_rcr, r_p_gcb, r_p_gcr, r_p_bcb;
  sync_t      r_s2_sync;
  logic [23:0] r_rgb;
  sync_t      r_s3_sync;

  assign w_sync_in = '{de: vid.de_i, hsync: vid.hsync_i, vsync: vid.vsync_i};
  assign w_in_odd  = vid.de_i & r_phase;

  // An even pixel in S1 borrows Cr from the odd pixel arriving now; if the line
  // ends instead, neutral chroma stands in. An odd pixel reuses the latched Cb.
  always_comb begin
    w_cb = r_s1_c;
    w_cr = w_in_odd ? vid.data422_i[7:0] : C_NEUTRAL;
    if (r_s1_odd) begin
      w_cb = r_cb_lat;
      w_cr = r_s1_c;
    end
  end

  assign w_yd  = acc_t'({12'd0, r_s1_y}) - Y_OFS;
  assign w_cbd = acc_t'({12'd0, w_cb})   - C_OFS;
  assign w_crd = acc_t'({12'd0, w_cr})   - C_OFS;

  always_ff @(posedge px_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase   <= 1'b0;
      r_s1_y    <= '0;
      r_s1_c    <= '0;
      r_s1_odd  <= 1'b0;
      r_cb_lat  <= '0;
      r_s1_sync <= '0;
      r_p_y     <= '0;
      r_p_rcr   <= '0;
      r_p_gcb   <= '0;
      r_p_gcr   <= '0;
      r_p_bcb   <= '0;
      r_s2_sync <= '0;
      r_rgb     <= '0;
      r_s3_sync <= '0;
    end else begin
      r_phase   <= vid.de_i ? ~r_phase : 1'b0;
      r_s1_y    <= vid.data422_i[15:8];
      r_s1_c    <= vid.data422_i[7:0];
      r_s1_odd  <= w_in_odd;
      r_cb_lat  <= r_s1_c;
      r_s1_sync <= w_sync_in;

      r_p_y     <= K_Y   * w_yd;
      r_p_rcr   <= K_RCR * w_crd;
      r_p_gcb   <= K_GCB * w_cbd;
      r_p_gcr   <= K_GCR * w_crd;
      r_p_bcb   <= K_BCB * w_cbd;
      r_s2_sync <= r_s1_sync;

      r_rgb     <= r_s2_sync.de ? {w_r, w_g, w_b} : 24'd0;
      r_s3_sync <= r_s2_sync;
    end
  end

  assign w_sum_r = r_p_y + r_p_rcr;
  assign w_sum_g = r_p_y - r_p_gcb - r_p_gcr;
  assign w_sum_b = r_p_y + r_p_bcb;

  paper_csc_clamp u_clamp_r (.i_acc(w_sum_r), .o_pix(w_r));
  paper_csc_clamp u_clamp_g (.i_acc(w_sum_g), .o_pix(w_g));
  paper_csc_clamp u_clamp_b (.i_acc(w_sum_b), .o_pix(w_b));

  assign vid.rgb_o   = r_rgb;
  assign vid.de_o    = r_s3_sync.de;
  assign vid.hsync_o = r_s3_sync.hsync;
  assign vid.vsync_o = r_s3_sync.vsync;

endmodule

// File: tb/tb_paper_ycbcr422_to_rgb.sv
// Bench for paper_ycbcr422_to_rgb: directed and random 4:2:2 streams against a per-line reference model.
module tb_paper_ycbcr422_to_rgb;

  localparam int MAXN = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  paper_ycbcr422_to_rgb_if vif();

  paper_ycbcr422_to_rgb dut (
    .px_clk_i (clk),
    .rst_ni   (rst_n),
    .vid      (vif)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n      = 0;

  logic [7:0]  s_y [MAXN];
  logic [7:0]  s_c [MAXN];
  logic        s_de[MAXN];
  logic        s_hs[MAXN];
  logic        s_vs[MAXN];
  logic [23:0] e_rgb [MAXN];
  logic [2:0]  e_sync[MAXN];
  logic [23:0] o_rgb [MAXN];
  logic        o_de  [MAXN];

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] y, input logic [7:0] c,
                       input logic de, input logic hs, input logic vs);
    vif.data422_i = {y, c};
    vif.de_i      = de;
    vif.hsync_i   = hs;
    vif.vsync_i   = vs;
  endtask

  task automatic push(input logic [7:0] y, input logic [7:0] c,
                      input logic de, input logic hs, input logic vs);
    if (n < MAXN) begin
      s_y[n] = y; s_c[n] = c; s_de[n] = de; s_hs[n] = hs; s_vs[n] = vs;
      n++;
    end
  endtask

  function automatic logic [7:0] sat(input int v);
    int q;
    q = (v + 128) >>> 8;
    if (q < 0)   return 8'd0;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
    int yy, r, g, b;
    yy = 298 * (y - 16);
    r  = yy + 409 * (cr - 128);
    g  = yy - 100 * (cb - 128) - 208 * (cr - 128);
    b  = yy + 516 * (cb - 128);
    return {sat(r), sat(g), sat(b)};
  endfunction

  // Walk each active run: even pixels take Cr from the following pixel when the
  // line continues (else 128), odd pixels take Cb from the preceding one.
  task automatic build_model();
    int idx = 0;
    int cb, cr;
    for (int t = 0; t < n; t++) begin
      e_sync[t] = {s_de[t], s_hs[t], s_vs[t]};
      if (!s_de[t]) begin
        idx      = 0;
        e_rgb[t] = 24'd0;
      end else begin
        if (idx % 2 == 0) begin
          cb = int'(s_c[t]);
          cr = (t + 1 < n && s_de[t+1]) ? int'(s_c[t+1]) : 128;
        end else begin
          cb = int'(s_c[t-1]);
          cr = int'(s_c[t]);
        end
        e_rgb[t] = ref_rgb(int'(s_y[t]), cb, cr);
        idx++;
      end
    end
  endtask

  task automatic run_stream(input string tag);
    build_model();
    for (int t = 0; t < n + 3; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        chk($sformatf("%s.rgb[%0d]", tag, t - 3), vif.rgb_o, e_rgb[t-3]);
        chk($sformatf("%s.sync[%0d]", tag, t - 3),
            {21'd0, vif.de_o, vif.hsync_o, vif.vsync_o}, {21'd0, e_sync[t-3]});
        o_rgb[t-3] = vif.rgb_o;
        o_de[t-3]  = vif.de_o;
      end
      if (t < n) drive(s_y[t], s_c[t], s_de[t], s_hs[t], s_vs[t]);
      else       drive(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic build_random();
    int g, l;
    n = 0;
    while (n < MAXN - 12) begin
      g = int'($urandom_range(1, 3));
      repeat (g) push(8'($urandom), 8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      l = int'($urandom_range(1, 9));
      repeat (l) push(8'($urandom), 8'($urandom), 1'b1, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Outputs held at zero while in reset regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst.rgb[%0d]", i), vif.rgb_o, 24'd0);
      chk($sformatf("rst.sync[%0d]", i), {21'd0, vif.de_o, vif.hsync_o, vif.vsync_o}, 24'd0);
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drive(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle.rgb[%0d]", i), vif.rgb_o, 24'd0);
      chk($sformatf("idle.de[%0d]", i), {23'd0, vif.de_o}, 24'd0);
      drive(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    end

    n = 0;
    repeat (8) push(8'd235, 8'd128, 1'b1, 1'b0, 1'b0);
    run_stream("white");
    chk("white.px0", o_rgb[0], 24'hFFFFFF);
    chk("white.px7", o_rgb[7], 24'hFFFFFF);

    n = 0;
    repeat (6) push(8'd16, 8'd128, 1'b1, 1'b1, 1'b0);
    run_stream("black");
    chk("black.px0", o_rgb[0], 24'h000000);
    chk("black.de0", {23'd0, o_de[0]}, 24'd1);

    n = 0;
    push(8'd81, 8'd90,  1'b1, 1'b0, 1'b0);
    push(8'd81, 8'd240, 1'b1, 1'b0, 1'b0);
    run_stream("red");
    chk("red.px0", o_rgb[0], 24'hFF0000);
    chk("red.px1", o_rgb[1], 24'hFF0000);

    n = 0;
    push(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    push(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    push(8'd128, 8'd200, 1'b1, 1'b0, 1'b0);
    run_stream("oddlen");
    chk("oddlen.px0", o_rgb[0], 24'h828282);
    chk("oddlen.px2", o_rgb[2], 24'h8266FF);

    for (int k = 0; k < 6; k++) begin
      build_random();
      run_stream($sformatf("rand%0d", k));
    end

    // Reset in the middle of a white line.
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      drive(8'd235, 8'd128, 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2;
    chk("midrst.before", vif.rgb_o, 24'hFFFFFF);
    rst_n = 1'b0;
    #1;
    chk("midrst.rgb", vif.rgb_o, 24'd0);
    chk("midrst.sync", {21'd0, vif.de_o, vif.hsync_o, vif.vsync_o}, 24'd0);
    @(negedge clk);
    drive(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    repeat (7) push(8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b1);
    push(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
    repeat (4) push(8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    run_stream("postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
